// File: rtl/seg7_disp_ctrl.sv
// rtl/seg7_disp_ctrl.sv - multi-digit 7-segment display controller, Avalon-MM slave
// Static or time-multiplexed drive, per-digit hex/raw decode, PWM brightness.
module seg7_disp_ctrl #(
  parameter int DIGITS     = 4,
  parameter int SCAN_DIV   = 1000,
  parameter int PWM_BITS   = 4,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic              sysclk,
  input  logic              sysreset,
  input  logic [4:0]        avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  output logic [31:0]       avs_readdata,
  output logic [DIGITS-1:0] hd_a,
  output logic [DIGITS-1:0] hd_b,
  output logic [DIGITS-1:0] hd_c,
  output logic [DIGITS-1:0] hd_d,
  output logic [DIGITS-1:0] hd_e,
  output logic [DIGITS-1:0] hd_f,
  output logic [DIGITS-1:0] hd_g,
  output logic [DIGITS-1:0] hd_dp,
  output logic [7:0]        mux_seg,
  output logic [DIGITS-1:0] mux_dig
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PRE_W = $clog2(SCAN_DIV);

  logic [2:0]          ctrl;
  logic [PWM_BITS-1:0] bright;
  logic [9:0]          digit_reg [DIGITS];

  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PRE_W-1:0]    presc;
  logic [IDX_W-1:0]    idx;

  logic                ctrl_en, ctrl_mux, ctrl_test;
  logic                digit_hit, mux_change, lit;
  logic [4:0]          dsel;
  logic [31:0]         rd_nxt;
  logic [7:0]          seg_on [DIGITS];
  logic [7:0][DIGITS-1:0] hd_nxt, hd_r;
  logic [7:0]          mux_seg_nxt;
  logic [DIGITS-1:0]   mux_dig_nxt, onehot;

  assign ctrl_en   = ctrl[0];
  assign ctrl_mux  = ctrl[1];
  assign ctrl_test = ctrl[2];

  // {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0:    hex7 = 7'h3F;
      4'h1:    hex7 = 7'h06;
      4'h2:    hex7 = 7'h5B;
      4'h3:    hex7 = 7'h4F;
      4'h4:    hex7 = 7'h66;
      4'h5:    hex7 = 7'h6D;
      4'h6:    hex7 = 7'h7D;
      4'h7:    hex7 = 7'h07;
      4'h8:    hex7 = 7'h7F;
      4'h9:    hex7 = 7'h6F;
      4'hA:    hex7 = 7'h77;
      4'hB:    hex7 = 7'h7C;
      4'hC:    hex7 = 7'h39;
      4'hD:    hex7 = 7'h5E;
      4'hE:    hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

  // Active-high {dp,g..a} for one digit before EN/PWM gating.
  function automatic logic [7:0] digit_segs(input logic [9:0] d, input logic test);
    logic [6:0] glyph;
    glyph = d[7] ? d[6:0] : hex7(d[3:0]);
    if (test)      digit_segs = 8'hFF;
    else if (d[9]) digit_segs = 8'h00;
    else           digit_segs = {d[8], glyph};
  endfunction

  assign dsel       = avs_address - 5'd2;
  assign digit_hit  = ({1'b0, avs_address} >= 6'd2) && ({1'b0, avs_address} < 6'(DIGITS + 2));
  assign mux_change = avs_write && (avs_address == 5'd0) && (avs_writedata[1] != ctrl_mux);

  always_ff @(posedge sysclk or posedge sysreset) begin
    if (sysreset) begin
      ctrl   <= 3'b001;
      bright <= '1;
      for (int i = 0; i < DIGITS; i++) digit_reg[i] <= 10'h200;
    end else if (avs_write) begin
      if (avs_address == 5'd0) ctrl <= avs_writedata[2:0];
      if (avs_address == 5'd1) bright <= avs_writedata[PWM_BITS-1:0];
      for (int i = 0; i < DIGITS; i++)
        if (digit_hit && dsel == 5'(i)) digit_reg[i] <= avs_writedata[9:0];
    end
  end

  // Counters keep running with EN=0 so re-enabling does not restart the scan.
  always_ff @(posedge sysclk or posedge sysreset) begin
    if (sysreset) begin
      pwm_cnt <= '0;
      presc   <= '0;
      idx     <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      if (mux_change) begin
        presc <= '0;
        idx   <= '0;
      end else if (presc == PRE_W'(SCAN_DIV - 1)) begin
        presc <= '0;
        idx   <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
      end else begin
        presc <= presc + 1'b1;
      end
    end
  end

  always_comb begin
    rd_nxt = 32'h0;
    if (avs_address == 5'd0) rd_nxt = {29'h0, ctrl};
    if (avs_address == 5'd1) rd_nxt = 32'(bright);
    for (int i = 0; i < DIGITS; i++)
      if (digit_hit && dsel == 5'(i)) rd_nxt = {22'h0, digit_reg[i]};
  end

  always_ff @(posedge sysclk or posedge sysreset) begin
    if (sysreset)      avs_readdata <= 32'h0;
    else if (avs_read) avs_readdata <= rd_nxt;
  end

  assign lit = ctrl_en && (pwm_cnt <= bright);

  always_comb begin
    hd_nxt      = '0;
    mux_seg_nxt = 8'h00;
    mux_dig_nxt = '0;
    onehot      = '0;
    for (int i = 0; i < DIGITS; i++) begin
      seg_on[i] = lit ? digit_segs(digit_reg[i], ctrl_test) : 8'h00;
      for (int s = 0; s < 8; s++) hd_nxt[s][i] = !ctrl_mux && seg_on[i][s];
      if (idx == IDX_W'(i)) onehot[i] = 1'b1;
    end
    if (ctrl_mux) begin
      for (int i = 0; i < DIGITS; i++)
        if (idx == IDX_W'(i)) mux_seg_nxt = seg_on[i];
      // First two prescaler counts of each slot keep every enable off to avoid ghosting.
      if (ctrl_en && presc >= PRE_W'(2)) mux_dig_nxt = onehot;
    end
  end

  // Registers hold the pin level so polarity inversion adds no output logic.
  always_ff @(posedge sysclk or posedge sysreset) begin
    if (sysreset) begin
      hd_r    <= {(8 * DIGITS){ACTIVE_LOW}};
      mux_seg <= {8{ACTIVE_LOW}};
      mux_dig <= {DIGITS{ACTIVE_LOW}};
    end else begin
      hd_r    <= hd_nxt ^ {(8 * DIGITS){ACTIVE_LOW}};
      mux_seg <= mux_seg_nxt ^ {8{ACTIVE_LOW}};
      mux_dig <= mux_dig_nxt ^ {DIGITS{ACTIVE_LOW}};
    end
  end

  assign hd_a  = hd_r[0];
  assign hd_b  = hd_r[1];
  assign hd_c  = hd_r[2];
  assign hd_d  = hd_r[3];
  assign hd_e  = hd_r[4];
  assign hd_f  = hd_r[5];
  assign hd_g  = hd_r[6];
  assign hd_dp = hd_r[7];

endmodule
